// File: rtl/ram_lane_ctrl.sv
// rtl/ram_lane_ctrl.sv - RV32I load/store front-end driving four byte-wide synchronous RAM lanes
module ram_lane_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH+1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_din_o,
  output logic [3:0]            ram_we_o,
  input  logic [31:0]           ram_dout_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t                state, state_next;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  accept;
  logic                  misaligned;
  logic                  req_err;
  logic [3:0]            we_mask;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic                  sign_ext;
  logic [31:0]           load_data;

  assign req_ready_o = (state == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3_i[1:0])
      2'd1:    misaligned = req_addr_i[0];
      2'd2:    misaligned = (req_addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (req_we_i) begin
      req_err = misaligned || (req_funct3_i > 3'd2);
    end else begin
      req_err = misaligned || (req_funct3_i == 3'd3) || (req_funct3_i[2:1] == 2'b11);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !req_err) state_next = ACCESS;
      ACCESS:  state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only legal stores reach ACCESS, so funct3_q[1:0] is 0, 1 or 2 here.
  always_comb begin
    we_mask   = 4'b1111;
    ram_din_o = wdata_q;
    case (funct3_q[1:0])
      2'd0: begin
        we_mask   = 4'b0001 << addr_q[1:0];
        ram_din_o = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        we_mask   = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_din_o = {2{wdata_q[15:0]}};
      end
      default: begin
        we_mask   = 4'b1111;
        ram_din_o = wdata_q;
      end
    endcase
  end

  assign ram_we_o   = (state == ACCESS && we_q && !rst_i) ? we_mask : 4'b0000;
  assign ram_addr_o = addr_q[ADDR_WIDTH+1:2];

  always_comb begin
    case (addr_q[1:0])
      2'd0:    sel_byte = ram_dout_i[7:0];
      2'd1:    sel_byte = ram_dout_i[15:8];
      2'd2:    sel_byte = ram_dout_i[23:16];
      default: sel_byte = ram_dout_i[31:24];
    endcase
    sel_half = addr_q[1] ? ram_dout_i[31:16] : ram_dout_i[15:0];
    sign_ext = !funct3_q[2];
    case (funct3_q[1:0])
      2'd0:    load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      2'd1:    load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: load_data = ram_dout_i;
    endcase
    if (we_q) load_data = 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rsp_err_o   <= 1'b0;
    end else begin
      state       <= state_next;
      rsp_valid_o <= 1'b0;
      if (accept && req_err) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= 1'b1;
        rsp_rdata_o <= 32'h0;
      end else if (state == CAPTURE) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= 1'b0;
        rsp_rdata_o <= load_data;
      end
    end
  end

  // Request fields are captured on accept so the core may drop them afterwards.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q     <= req_we_i;
      funct3_q <= req_funct3_i;
      addr_q   <= req_addr_i;
      wdata_q  <= req_wdata_i;
    end
  end

endmodule
